// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit
// Program-counter unit for the fetch stage. Holds the architectural PC and
// advances it by 4 (or by 2 for compressed instructions when ALIGN_C=1).
// Also services branch/jump redirects, traps and stalls, and buffers one
// redirect that arrives while fetch is stalled. A misaligned redirect target
// is not taken: the PC goes to TRAP_VECTOR and the target is kept in bad_addr.
//
// Parameters
//   XLEN          datapath and address width
//   RESET_VECTOR  PC value loaded on reset
//   TRAP_VECTOR   PC value loaded on trap or misaligned redirect
//   ALIGN_C       1: compressed support (2-byte alignment, step 2 allowed)
//                 0: 4-byte alignment required
//
// Ports
//   clk              clock, all state updates on the rising edge
//   rst_n            asynchronous active-low reset
//   stall            hold the PC; sequential advance suppressed
//   compressed       current instruction is 16-bit (only used when ALIGN_C=1)
//   redirect_valid   branch/jump taken this cycle
//   redirect_target  branch/jump destination
//   trap             exception/interrupt request, highest priority
//   pc               current fetch address (registered)
//   pc_next_seq      pc + step (combinational)
//   pc_valid         pc is a valid fetch address (registered)
//   pending          a redirect is buffered (registered)
//   misaligned       one-cycle pulse after a misaligned redirect was trapped
//   bad_addr         target of the last misaligned redirect (registered)
// -----------------------------------------------------------------------------
module pc_unit #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter bit              ALIGN_C      = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            compressed,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_next_seq,
    output logic            pc_valid,
    output logic            pending,
    output logic            misaligned,
    output logic [XLEN-1:0] bad_addr
);

    localparam int unsigned STEP_FULL = 4;
    localparam int unsigned STEP_HALF = 2;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // State and architectural registers
    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_pc_valid;
    logic            r_pending;
    logic            r_misaligned;
    logic [XLEN-1:0] r_bad_addr;
    logic [XLEN-1:0] r_buf;

    // Next-state values
    state_t          w_state_nxt;
    logic [XLEN-1:0] w_pc_nxt;
    logic            w_pc_valid_nxt;
    logic            w_pending_nxt;
    logic            w_misaligned_nxt;
    logic [XLEN-1:0] w_bad_addr_nxt;
    logic [XLEN-1:0] w_buf_nxt;

    logic [XLEN-1:0] w_step;
    logic [XLEN-1:0] w_pc_seq;
    logic            w_tgt_bad;
    logic            w_redir_ok;
    logic            w_redir_bad;

    // Sequential step; compressed is ignored when compressed support is off
    assign w_step   = (ALIGN_C && compressed) ? XLEN'(STEP_HALF) : XLEN'(STEP_FULL);
    assign w_pc_seq = r_pc + w_step;

    // Alignment check of the live redirect target
    assign w_tgt_bad   = ALIGN_C ? redirect_target[0] : (redirect_target[1:0] != 2'b00);
    assign w_redir_ok  = redirect_valid && !w_tgt_bad;
    assign w_redir_bad = redirect_valid &&  w_tgt_bad;

    // State register and architectural registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_BOOT;
            r_pc         <= RESET_VECTOR;
            r_pc_valid   <= 1'b0;
            r_pending    <= 1'b0;
            r_misaligned <= 1'b0;
            r_bad_addr   <= '0;
            r_buf        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_pc_valid   <= w_pc_valid_nxt;
            r_pending    <= w_pending_nxt;
            r_misaligned <= w_misaligned_nxt;
            r_bad_addr   <= w_bad_addr_nxt;
            r_buf        <= w_buf_nxt;
        end
    end

    // Next-state and next-value logic
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_pc_valid_nxt   = r_pc_valid;
        w_pending_nxt    = r_pending;
        w_misaligned_nxt = 1'b0;
        w_bad_addr_nxt   = r_bad_addr;
        w_buf_nxt        = r_buf;

        case (r_state)
            // One settling cycle after reset; all inputs ignored
            ST_BOOT: begin
                w_state_nxt    = ST_RUN;
                w_pc_valid_nxt = 1'b1;
            end

            ST_RUN: begin
                if (trap) begin
                    w_pc_nxt = TRAP_VECTOR;
                end else if (w_redir_bad) begin
                    w_pc_nxt         = TRAP_VECTOR;
                    w_misaligned_nxt = 1'b1;
                    w_bad_addr_nxt   = redirect_target;
                end else if (w_redir_ok && stall) begin
                    w_buf_nxt   = redirect_target;
                    w_state_nxt = ST_WAIT;
                end else if (w_redir_ok) begin
                    w_pc_nxt = redirect_target;
                end else if (!stall) begin
                    w_pc_nxt = w_pc_seq;
                end
            end

            ST_WAIT: begin
                if (trap) begin
                    // Buffered and live redirects are both dropped
                    w_pc_nxt    = TRAP_VECTOR;
                    w_state_nxt = ST_RUN;
                end else if (w_redir_bad) begin
                    w_pc_nxt         = TRAP_VECTOR;
                    w_misaligned_nxt = 1'b1;
                    w_bad_addr_nxt   = redirect_target;
                    w_state_nxt      = ST_RUN;
                end else if (stall) begin
                    // Youngest aligned redirect replaces the buffered one
                    if (w_redir_ok) begin
                        w_buf_nxt = redirect_target;
                    end
                end else begin
                    // Stall released: a live redirect beats the buffered one
                    w_pc_nxt    = w_redir_ok ? redirect_target : r_buf;
                    w_state_nxt = ST_RUN;
                end
            end

            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase

        // pending tracks WAIT exactly
        w_pending_nxt = (w_state_nxt == ST_WAIT);
    end

    assign pc          = r_pc;
    assign pc_next_seq = w_pc_seq;
    assign pc_valid    = r_pc_valid;
    assign pending     = r_pending;
    assign misaligned  = r_misaligned;
    assign bad_addr    = r_bad_addr;

endmodule

// File: tb/tb_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_unit
// Drives two pc_unit instances (ALIGN_C=0 and ALIGN_C=1) with the same
// stimulus. A reference model computes each edge's expected outputs when the
// stimulus is driven; they are queued and compared after the edge.
// -----------------------------------------------------------------------------
module tb_pc_unit;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;

    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_WAIT = 2;

    typedef struct {
        int          st;
        logic [31:0] pc;
        logic [31:0] bf;
        logic [31:0] bad;
        logic        valid;
        logic        pend;
        logic        mis;
    } mdl_t;

    typedef struct {
        mdl_t        e0;
        mdl_t        e1;
        logic [31:0] nseq0;
        logic [31:0] nseq1;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0;
    logic        compressed = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        trap = 1'b0;

    logic [31:0] pc0, nseq0, bad0, pc1, nseq1, bad1;
    logic        valid0, pend0, mis0, valid1, pend1, mis1;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t q[$];
    mdl_t m0, m1;

    always #5 clk = ~clk;

    pc_unit #(
        .XLEN(32), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .ALIGN_C(1'b0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .compressed(compressed),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .trap(trap), .pc(pc0), .pc_next_seq(nseq0), .pc_valid(valid0),
        .pending(pend0), .misaligned(mis0), .bad_addr(bad0)
    );

    pc_unit #(
        .XLEN(32), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .ALIGN_C(1'b1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .compressed(compressed),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .trap(trap), .pc(pc1), .pc_next_seq(nseq1), .pc_valid(valid1),
        .pending(pend1), .misaligned(mis1), .bad_addr(bad1)
    );

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.st = M_BOOT; m.pc = RV; m.bf = 32'h0; m.bad = 32'h0;
        m.valid = 1'b0; m.pend = 1'b0; m.mis = 1'b0;
        return m;
    endfunction

    function automatic logic [31:0] step_of(bit alc, bit cmp);
        return (alc && cmp) ? 32'd2 : 32'd4;
    endfunction

    // Behaviour of one rising edge as described for the PC unit
    function automatic mdl_t mdl_next(mdl_t m, bit alc, bit st, bit cmp,
                                      bit rv, logic [31:0] tgt, bit tr);
        mdl_t n;
        bit   bad;
        n     = m;
        n.mis = 1'b0;
        bad   = alc ? (tgt[0] != 1'b0) : (tgt[1:0] != 2'b00);
        if (m.st == M_BOOT) begin
            n.st    = M_RUN;
            n.valid = 1'b1;
        end else if (tr) begin
            n.pc = TV;
            n.st = M_RUN;
        end else if (rv && bad) begin
            n.pc  = TV;
            n.mis = 1'b1;
            n.bad = tgt;
            n.st  = M_RUN;
        end else if (m.st == M_RUN) begin
            if (rv && st) begin
                n.bf = tgt;
                n.st = M_WAIT;
            end else if (rv) begin
                n.pc = tgt;
            end else if (!st) begin
                n.pc = m.pc + step_of(alc, cmp);
            end
        end else begin
            if (st) begin
                if (rv) n.bf = tgt;
            end else begin
                n.pc = rv ? tgt : m.bf;
                n.st = M_RUN;
            end
        end
        n.pend = (n.st == M_WAIT);
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_dut(input string p, input mdl_t e, input logic [31:0] ens,
                           input logic [31:0] opc, input logic ov, input logic op,
                           input logic om, input logic [31:0] ob, input logic [31:0] ons);
        chk({p, ".pc"},          opc,            e.pc);
        chk({p, ".pc_valid"},    32'(ov),        32'(e.valid));
        chk({p, ".pending"},     32'(op),        32'(e.pend));
        chk({p, ".misaligned"},  32'(om),        32'(e.mis));
        chk({p, ".bad_addr"},    ob,             e.bad);
        chk({p, ".pc_next_seq"}, ons,            ens);
    endtask

    // Drive one cycle of stimulus, queue the expectation, compare after the edge
    task automatic step(input bit st, input bit cmp, input bit rv,
                        input logic [31:0] tgt, input bit tr);
        exp_t x;
        stall = st; compressed = cmp; redirect_valid = rv;
        redirect_target = tgt; trap = tr;
        m0 = mdl_next(m0, 1'b0, st, cmp, rv, tgt, tr);
        m1 = mdl_next(m1, 1'b1, st, cmp, rv, tgt, tr);
        x.e0 = m0; x.e1 = m1;
        x.nseq0 = m0.pc + step_of(1'b0, cmp);
        x.nseq1 = m1.pc + step_of(1'b1, cmp);
        q.push_back(x);
        @(posedge clk);
        #1;
        x = q.pop_front();
        chk_dut("a0", x.e0, x.nseq0, pc0, valid0, pend0, mis0, bad0, nseq0);
        chk_dut("a1", x.e1, x.nseq1, pc1, valid1, pend1, mis1, bad1, nseq1);
    endtask

    // Assert reset away from the clock edge and check it takes effect at once
    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        m0 = mdl_reset();
        m1 = mdl_reset();
        q.delete();
        chk("rst.pc0",      pc0,           RV);
        chk("rst.pc1",      pc1,           RV);
        chk("rst.valid0",   32'(valid0),   32'h0);
        chk("rst.pending0", 32'(pend0),    32'h0);
        chk("rst.pending1", 32'(pend1),    32'h0);
        chk("rst.mis0",     32'(mis0),     32'h0);
        chk("rst.bad0",     bad0,          32'h0);
        @(negedge clk);
        stall = 1'b0; compressed = 1'b0; redirect_valid = 1'b0; trap = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] t;
        #1;
        async_reset();

        // Boot then sequential run: 0, 4, 8, C
        step(0, 0, 0, 32'h0, 0);
        chk("boot.pc", pc0, 32'h0);
        step(0, 0, 0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 0);
        chk("seq.pc_c", pc0, 32'h0000_000C);

        // Wrap-around
        step(0, 0, 1, 32'hFFFF_FFFC, 0);
        step(0, 0, 0, 32'h0, 0);
        chk("wrap.pc", pc0, 32'h0000_0000);

        // Stalled redirects, youngest wins on release
        step(1, 0, 1, 32'h0000_0200, 0);
        step(1, 0, 1, 32'h0000_0300, 0);
        step(1, 0, 0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 0);
        chk("release.pc", pc0, 32'h0000_0300);

        // Misaligned by 2: trap for ALIGN_C=0, taken for ALIGN_C=1
        step(0, 0, 1, 32'h0000_0102, 0);
        chk("mis.bad0", bad0, 32'h0000_0102);
        chk("mis.pc1",  pc1,  32'h0000_0102);
        step(0, 1, 0, 32'h0, 0);
        chk("cstep.pc1", pc1, 32'h0000_0104);
        // Odd target traps in both builds
        step(0, 0, 1, 32'h0000_0103, 0);
        step(0, 1, 0, 32'h0, 0);

        // Misaligned redirect while waiting clears the buffer
        step(1, 0, 1, 32'h0000_0500, 0);
        step(1, 0, 1, 32'h0000_0501, 0);
        step(1, 0, 0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 0);

        // Trap + redirect + stall in WAIT: trap wins
        step(1, 0, 1, 32'h0000_0200, 0);
        step(1, 0, 1, 32'h0000_0400, 1);
        chk("trapw.pc", pc0, TV);
        step(0, 0, 0, 32'h0, 0);
        // Trap in RUN, then live redirect beating the buffer on release
        step(0, 0, 1, 32'h0000_0800, 1);
        step(1, 0, 1, 32'h0000_0600, 0);
        step(0, 0, 1, 32'h0000_0700, 0);
        chk("live.pc", pc0, 32'h0000_0700);

        // Async reset in WAIT; BOOT ignores a trap; buffer never loaded
        step(1, 0, 1, 32'h0000_0300, 0);
        #2;
        async_reset();
        step(1, 0, 1, 32'h0000_0900, 1);
        step(0, 0, 0, 32'h0, 0);
        chk("postrst.pc", pc0, 32'h0000_0004);

        // Mixed pseudo-random traffic
        for (int i = 0; i < 60; i++) begin
            t = $urandom;
            if ($urandom_range(0, 1) == 0) t[1:0] = 2'b00;
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) == 0), t, ($urandom_range(0, 15) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the RISC-V core's fetch stage, generalising the fixed PC+4 adder. Holds the architectural PC in a register and advances it sequentially by 4 (or 2 for compressed instructions). It also services branch/jump redirects, traps, pipeline stalls and a one-entry pending-redirect buffer for redirects that arrive while fetch is stalled. It flags misaligned redirect targets and vectors them to the trap handler.

## Interface
- XLEN, 32, datapath and address width
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
- TRAP_VECTOR, 32'h0000_0100, PC value loaded on trap or misaligned redirect
- ALIGN_C, 0, 1 enables compressed support (2-byte alignment and step 2); 0 requires 4-byte alignment
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- stall  input  1  hold PC; sequential advance suppressed
- compressed  input  1  current instruction is 16-bit; honoured only when ALIGN_C=1
- redirect_valid  input  1  branch/jump taken this cycle
- redirect_target  input  XLEN  branch/jump destination
- trap  input  1  exception/interrupt request, highest priority
- pc  output  XLEN  current fetch address (registered)
- pc_next_seq  output  XLEN  pc + step, combinational
- pc_valid  output  1  pc is a valid fetch address (registered)
- pending  output  1  a redirect is buffered (registered)
- misaligned  output  1  one-cycle pulse: a misaligned redirect was taken as a trap
- bad_addr  output  XLEN  faulting target of the last misaligned redirect (registered)

## Operation
- step = 2 when ALIGN_C=1 and compressed=1, else 4. pc_next_seq = pc + step, truncated to XLEN bits (wraps modulo 2^XLEN).
- Misaligned target: redirect_target[1:0]!=0 when ALIGN_C=0; redirect_target[0]!=0 when ALIGN_C=1.
- States: BOOT, RUN, WAIT.
  - BOOT: entered on reset; pc_valid=0; next edge goes to RUN unconditionally, with pc unchanged. Inputs are ignored in BOOT.
  - RUN: per-edge priority, highest first:
    - trap: pc<=TRAP_VECTOR.
    - redirect_valid misaligned: pc<=TRAP_VECTOR, misaligned<=1, bad_addr<=target.
    - redirect_valid with stall=1: buffer target, pending<=1, go to WAIT; pc held.
    - redirect_valid with stall=0: pc<=target.
    - stall: pc held.
    - otherwise: pc<=pc_next_seq.
  - WAIT: pc held while stall=1.
    - A new aligned redirect overwrites the buffer (youngest wins).
    - A misaligned redirect in WAIT acts as in RUN, clears pending and returns to RUN.
    - When stall=0: pc<=buffered target, or redirect_target if redirect_valid is aligned in the same cycle (live redirect wins). pending<=0, then go to RUN.
- trap in any state except BOOT: pc<=TRAP_VECTOR, pending<=0, state<=RUN, regardless of stall.
- Misaligned targets are checked before buffering, so the buffer only ever holds aligned targets.
- Reset values: pc=RESET_VECTOR, pc_valid=0, pending=0, misaligned=0, bad_addr=0, state=BOOT.
- Reset asserted mid-operation: all registers return to reset values immediately (asynchronously), discarding any buffered redirect.
- misaligned is high for exactly the one cycle after the faulting edge. bad_addr holds its value until the next misaligned event.

## Timing
- pc updates one edge after the controlling inputs are sampled. Redirect latency is 1 cycle when stall=0, and 1 cycle after stall deasserts when buffered.
- pc_next_seq is combinational from pc and compressed, with zero latency.
- pc_valid rises on the first edge after rst_n deasserts and stays high until the next reset.
- pending is high exactly while in WAIT.
- Simultaneous trap, redirect_valid and stall: trap wins and the redirect is discarded.

## Test plan
- Reset then run, ALIGN_C=0: pc=0, pc_valid=0 for 1 cycle, then pc=0,4,8,C on successive edges with pc_valid=1.
- Wrap-around: redirect to FFFF_FFFC with stall=0 → next pc=FFFF_FFFC, following pc=0000_0000.
- Stalled redirect: stall=1, redirect to 0x200 then to 0x300 → pending=1, pc held. Release stall → pc=0x300, pending=0.
- Misaligned: ALIGN_C=0, redirect to 0x102 → pc=0x100, misaligned pulses 1 cycle, bad_addr=0x102. With ALIGN_C=1 the same target loads pc=0x102 and a compressed step gives 0x104.
- Trap priority: trap, redirect_valid (0x400) and stall all high in WAIT → pc=0x100, pending=0, state RUN.
- Async reset: assert rst_n=0 mid-WAIT with 0x300 buffered → pc=RESET_VECTOR and pending=0 immediately. After release, BOOT repeats and the buffered target is never loaded.
